// File: rtl/sobel_window3x3_pkg.sv
// Shared definitions for the Sobel 3x3 front end: pixel format, default image
// geometry, counter widths and the window-generator FSM encoding.
package sobel_window3x3_pkg;

  // RGB444 pixel: {R[11:8], G[7:4], B[3:0]}
  localparam int PIX_W = 12;
  localparam int CH_W  = 4;
  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  localparam int DEF_IMG_WIDTH  = 320;
  localparam int DEF_IMG_HEIGHT = 240;
  localparam int DEF_X_W        = $clog2(DEF_IMG_WIDTH);
  localparam int DEF_Y_W        = $clog2(DEF_IMG_HEIGHT);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } win_state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line store with synchronous, read-before-write access.
//  clk      in   clock
//  i_en     in   access strobe: read mem[i_addr] into o_rdata and write i_wdata
//  i_addr   in   AW   location
//  i_wdata  in   DW   data written this access
//  o_rdata  out  DW   previous contents of i_addr, held between accesses
// Contents are never cleared; consumers mask stale data themselves.
module sobel_line_buffer #(
  parameter int DEPTH = 320,
  parameter int AW    = 9,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      o_rdata        <= r_mem[i_addr];
      r_mem[i_addr]  <= i_wdata;
    end
  end

endmodule

// File: rtl/sobel_window3x3.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel kernel.
//  clk, reset            pixel clock, synchronous active-high reset
//  in_valid/in_sof       pixel strobe; in_sof marks pixel (0,0) of a frame
//  in_pixel              raster-order RGB444 pixel
//  out_valid             one-cycle pulse, 2 clocks after the (x,y) pixel
//  out_lu..out_rd        window, l/m/r = col x-2/x-1/x, u/m/d = row y-2/y-1/y
//  out_x, out_y          window centre (x-1, y-1)
// Only pixels with x>=2 && y>=2 produce a window; outputs hold otherwise.
module sobel_window3x3
  import sobel_window3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int X_W        = $clog2(IMG_WIDTH),
  parameter int Y_W        = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_lu,
  output logic [PIX_W-1:0] out_lm,
  output logic [PIX_W-1:0] out_ld,
  output logic [PIX_W-1:0] out_mu,
  output logic [PIX_W-1:0] out_mm,
  output logic [PIX_W-1:0] out_md,
  output logic [PIX_W-1:0] out_ru,
  output logic [PIX_W-1:0] out_rm,
  output logic [PIX_W-1:0] out_rd,
  output logic [X_W-1:0]   out_x,
  output logic [Y_W-1:0]   out_y
);

  localparam logic [X_W-1:0] X_LAST  = X_W'(IMG_WIDTH - 1);
  localparam logic [X_W-1:0] P2_LAST = X_W'(IMG_WIDTH - 2);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(IMG_HEIGHT - 1);
  localparam logic [X_W-1:0] X_ONE   = X_W'(1);
  localparam logic [X_W-1:0] X_TWO   = X_W'(2);
  localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1);
  localparam logic [Y_W-1:0] Y_TWO   = Y_W'(2);

  win_state_e       r_state, w_state_nxt;
  logic             w_accept;
  logic [X_W-1:0]   r_x, w_px;
  logic [Y_W-1:0]   r_y, w_py;
  logic [X_W-1:0]   r_p2;
  logic             w_gate;

  // ---- FSM and current pixel position --------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_SOF;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_px        = r_x;
    w_py        = r_y;
    case (r_state)
      WAIT_SOF: if (in_valid && in_sof) begin
        w_state_nxt = RUN;
        w_accept    = 1'b1;
      end
      RUN:      w_accept = in_valid;
      default:  w_state_nxt = WAIT_SOF;
    endcase
    // sof forces (0,0) whatever the counters say
    if (in_valid && in_sof) begin
      w_px = '0;
      w_py = '0;
    end
  end

  assign w_gate = (w_px >= X_TWO) && (w_py >= Y_TWO);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x  <= '0;
      r_y  <= '0;
      r_p2 <= '0;
    end else if (w_accept) begin
      if (w_px == X_LAST) begin
        r_x <= '0;
        r_y <= (w_py == Y_LAST) ? '0 : w_py + Y_ONE;
      end else begin
        r_x <= w_px + X_ONE;
        r_y <= w_py;
      end
      r_p2 <= (r_p2 == P2_LAST) ? '0 : r_p2 + X_ONE;
    end
  end

  // ---- Line store -----------------------------------------------------------
  // Row y-1 buffer is addressed by column. Its read data arrives one accepted
  // pixel late, so the row y-2 buffer is a free-running ring of IMG_WIDTH-1
  // entries: that depth plus the one-pixel read lag is exactly one line, which
  // lines its output up with the row y-1 read of the same column.
  logic [PIX_W-1:0] w_row1, w_row2;

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(X_W), .DW(PIX_W)) u_row1 (
    .clk     (clk),
    .i_en    (w_accept),
    .i_addr  (w_px),
    .i_wdata (in_pixel),
    .o_rdata (w_row1)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH - 1), .AW(X_W), .DW(PIX_W)) u_row2 (
    .clk     (clk),
    .i_en    (w_accept),
    .i_addr  (r_p2),
    .i_wdata (w_row1),
    .o_rdata (w_row2)
  );

  // ---- Stage 1: pixel, gate and centre alongside the RAM reads ---------------
  logic             r_v1, r_g1;
  logic [PIX_W-1:0] r_pix1;
  logic [X_W-1:0]   r_cx1;
  logic [Y_W-1:0]   r_cy1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_g1   <= 1'b0;
      r_pix1 <= '0;
      r_cx1  <= '0;
      r_cy1  <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_g1   <= w_gate;
        r_pix1 <= in_pixel;
        r_cx1  <= w_px - X_ONE;
        r_cy1  <= w_py - Y_ONE;
      end
    end
  end

  // ---- Stage 2: column shift and output capture ------------------------------
  // Columns are [2]=row y-2, [1]=row y-1, [0]=row y. The two stored columns
  // plus the arriving one form the window; the left column falls off on shift.
  logic [2:0][PIX_W-1:0] r_col_l, r_col_m, w_col_r;

  assign w_col_r = {w_row2, w_row1, r_pix1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_l   <= '0;
      r_col_m   <= '0;
      out_valid <= 1'b0;
      out_lu    <= '0;
      out_lm    <= '0;
      out_ld    <= '0;
      out_mu    <= '0;
      out_mm    <= '0;
      out_md    <= '0;
      out_ru    <= '0;
      out_rm    <= '0;
      out_rd    <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= r_v1 && r_g1;
      if (r_v1) begin
        r_col_l <= r_col_m;
        r_col_m <= w_col_r;
        if (r_g1) begin
          out_lu <= r_col_l[2];
          out_lm <= r_col_l[1];
          out_ld <= r_col_l[0];
          out_mu <= r_col_m[2];
          out_mm <= r_col_m[1];
          out_md <= r_col_m[0];
          out_ru <= w_col_r[2];
          out_rm <= w_col_r[1];
          out_rd <= w_col_r[0];
          out_x  <= r_cx1;
          out_y  <= r_cy1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window3x3.sv
module tb_sobel_window3x3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_sof;
  logic [PW-1:0] in_pixel;
  logic          out_valid;
  logic [PW-1:0] out_lu, out_lm, out_ld, out_mu, out_mm, out_md, out_ru, out_rm, out_rd;
  logic [1:0]    out_x;
  logic [1:0]    out_y;

  sobel_window3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .X_W(2), .Y_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid),
    .out_lu(out_lu), .out_lm(out_lm), .out_ld(out_ld),
    .out_mu(out_mu), .out_mm(out_mm), .out_md(out_md),
    .out_ru(out_ru), .out_rm(out_rm), .out_rd(out_rd),
    .out_x(out_x), .out_y(out_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0][PW-1:0] w;   // 0=lu 1=lm 2=ld 3=mu 4=mm 5=md 6=ru 7=rm 8=rd
    int cx;
    int cy;
    int due;
  } exp_t;

  exp_t q[$];

  // reference model: frame image indexed by position, spec-level counters
  bit            m_run;
  int            m_x, m_y;
  logic [PW-1:0] img [H][W];

  int n_chk = 0, n_err = 0, n_win = 0;
  bit have_first = 1'b0;
  logic [PW-1:0] first_lu, first_mm, first_rd;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(bit v, bit s, logic [PW-1:0] p);
    exp_t e;
    @(posedge clk); #1;
    in_valid = v; in_sof = s; in_pixel = p;
    if (v && (s || m_run)) begin
      if (s) begin m_run = 1'b1; m_x = 0; m_y = 0; end
      img[m_y][m_x] = p;
      if (m_x >= 2 && m_y >= 2) begin
        for (int c = 0; c < 3; c++)
          for (int r = 0; r < 3; r++)
            e.w[c*3+r] = img[m_y-2+r][m_x-2+c];
        e.cx = m_x - 1; e.cy = m_y - 1; e.due = cyc + 2;
        q.push_back(e);
      end
      m_x++;
      if (m_x == W) begin m_x = 0; m_y++; if (m_y == H) m_y = 0; end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    m_run = 1'b0; m_x = 0; m_y = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_pix", 128'({out_lu, out_lm, out_ld, out_mu, out_mm, out_md, out_ru, out_rm, out_rd}), 128'(0));
    chk("rst_xy", 128'({out_x, out_y}), 128'(0));
  endtask

  // frame: pattern 16*y+x (+base) or random; optional gaps between pixels
  task automatic frame(bit sof, bit gaps, bit rnd, logic [PW-1:0] base);
    logic [PW-1:0] p;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        p = rnd ? PW'($urandom) : PW'(16*y + x) + base;
        drive(1'b1, sof && x == 0 && y == 0, p);
        if (gaps) drive(1'b0, 1'b0, PW'($urandom));
      end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    logic [8:0][PW-1:0] got;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      chk("win_missed", 128'(cyc), 128'(e.due));
    end
    if (out_valid) begin
      n_win++;
      got = {out_rd, out_rm, out_ru, out_md, out_mm, out_mu, out_ld, out_lm, out_lu};
      if (!have_first) begin
        have_first = 1'b1; first_lu = out_lu; first_mm = out_mm; first_rd = out_rd;
      end
      if (q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_window: got out_valid=1 centre (%0d,%0d) expected none", out_x, out_y);
      end else begin
        e = q.pop_front();
        chk("win_pixels", 128'(got), 128'(e.w));
        chk("win_centre", 128'({out_x, out_y}), 128'({e.cx[1:0], e.cy[1:0]}));
        chk("win_latency", 128'(cyc), 128'(e.due));
      end
    end
  end

  int w0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    m_run = 1'b0; m_x = 0; m_y = 0;
    repeat (3) @(posedge clk);
    do_reset();

    // 1: continuous 4x4 frame
    w0 = n_win;
    frame(1'b1, 1'b0, 1'b0, '0);
    idle(5);
    chk("s1_count", 128'(n_win - w0), 128'(4));
    chk("s1_first_lu", 128'(first_lu), 128'(12'h000));
    chk("s1_first_mm", 128'(first_mm), 128'(12'h011));
    chk("s1_first_rd", 128'(first_rd), 128'(12'h022));

    // 2: same frame, in_valid toggling
    w0 = n_win;
    frame(1'b1, 1'b1, 1'b0, '0);
    idle(5);
    chk("s2_count", 128'(n_win - w0), 128'(4));

    // 3: reset, junk without sof, then a real frame
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, PW'($urandom));
    w0 = n_win;
    frame(1'b1, 1'b0, 1'b0, '0);
    idle(5);
    chk("s3_count", 128'(n_win - w0), 128'(4));

    // 4: two back-to-back frames, sof only on the first
    w0 = n_win;
    frame(1'b1, 1'b0, 1'b0, 12'h100);
    frame(1'b0, 1'b0, 1'b1, '0);
    idle(5);
    chk("s4_count", 128'(n_win - w0), 128'(8));

    // 5: sof at (3,2) restarts the frame
    w0 = n_win;
    for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, PW'(16*(i/4) + i%4) + 12'h200);
    frame(1'b1, 1'b0, 1'b0, 12'h800);
    idle(5);
    chk("s5_count", 128'(n_win - w0), 128'(5));

    // 6: reset mid-frame; the rest of that frame must produce nothing
    for (int i = 0; i < 11; i++) drive(1'b1, i == 0, PW'($urandom));
    do_reset();
    w0 = n_win;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, PW'($urandom));
    idle(5);
    chk("s6_count", 128'(n_win - w0), 128'(0));

    // randomized traffic: random gaps, data and occasional sof
    drive(1'b1, 1'b1, PW'($urandom));
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0), PW'($urandom));
    idle(6);

    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
